// File: rtl/partial_cnu_gen.sv
// Split-row min-sum check node unit: folds a row arriving as ROW_SPLIT_FACTOR segments,
// then drains c2v messages from one of two result banks while the next row accumulates.
module partial_cnu_gen #(
    parameter int unsigned CN_DEGREE        = 10,
    parameter int unsigned QUAN_SIZE        = 4,
    parameter int unsigned MAG_SIZE         = 3,
    parameter int unsigned ROW_SPLIT_FACTOR = 5,
    parameter int unsigned OFFSET           = 1
) (
    input  logic                                              sys_clk,
    input  logic                                              rst,
    input  logic [(CN_DEGREE/ROW_SPLIT_FACTOR)*QUAN_SIZE-1:0] var_to_ch,
    input  logic                                              in_valid,
    input  logic                                              first_comp,
    input  logic                                              ms_mode,
    output logic [(CN_DEGREE/ROW_SPLIT_FACTOR)*QUAN_SIZE-1:0] ch_to_var,
    output logic                                              out_valid,
    output logic                                              out_first,
    output logic                                              row_abort
);
    localparam int unsigned EXT_MSG_PARALLELISM = CN_DEGREE / ROW_SPLIT_FACTOR;
    localparam int unsigned MW    = EXT_MSG_PARALLELISM * QUAN_SIZE;
    localparam int unsigned IDX_W = (CN_DEGREE > 1) ? $clog2(CN_DEGREE) : 1;
    localparam int unsigned SEG_W = (ROW_SPLIT_FACTOR > 1) ? $clog2(ROW_SPLIT_FACTOR) : 1;
    localparam logic [SEG_W-1:0]    LAST_SEG = SEG_W'(ROW_SPLIT_FACTOR - 1);
    localparam logic [MAG_SIZE-1:0] OFF_M    = MAG_SIZE'(OFFSET);

    typedef enum logic {StIdle, StAcc} state_e;

    state_e                state_q, state_d;
    logic [SEG_W-1:0]      seg_cnt_q, seg_cnt_d;
    logic [MAG_SIZE-1:0]   min1_q, min1_d, min2_q, min2_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  sp_q, sp_d, mode_q, mode_d;
    logic [CN_DEGREE-1:0]  signs_q, signs_d;

    logic [MAG_SIZE-1:0]   bank_min1_q [2], bank_min1_d [2];
    logic [MAG_SIZE-1:0]   bank_min2_q [2], bank_min2_d [2];
    logic [IDX_W-1:0]      bank_idx_q [2], bank_idx_d [2];
    logic                  bank_sp_q [2], bank_sp_d [2];
    logic                  bank_mode_q [2], bank_mode_d [2];
    logic [CN_DEGREE-1:0]  bank_signs_q [2], bank_signs_d [2];
    logic                  wr_bank_q, wr_bank_d;

    logic                  drain_act_q, drain_act_d, drain_bank_q, drain_bank_d;
    logic [SEG_W-1:0]      drain_seg_q, drain_seg_d;
    logic [MW-1:0]         c2v_q, c2v_d;
    logic                  out_valid_q, out_valid_d, out_first_q, out_first_d;
    logic                  abort_q, abort_d;

    logic [MAG_SIZE-1:0]   f_min1, f_min2, acc_mag, dr_mag;
    logic [IDX_W-1:0]      f_idx, acc_eidx, dr_eidx;
    logic                  f_sp, f_mode, accept, wr_en, dr_sign;
    logic [CN_DEGREE-1:0]  f_signs;
    logic [SEG_W-1:0]      seg_idx;
    logic [QUAN_SIZE-1:0]  acc_lane;

    // Accumulate FSM and fold; a first_comp segment always restarts the row.
    always_comb begin
        state_d      = state_q;
        seg_cnt_d    = seg_cnt_q;
        min1_d       = min1_q;
        min2_d       = min2_q;
        idx_d        = idx_q;
        sp_d         = sp_q;
        signs_d      = signs_q;
        mode_d       = mode_q;
        bank_min1_d  = bank_min1_q;
        bank_min2_d  = bank_min2_q;
        bank_idx_d   = bank_idx_q;
        bank_sp_d    = bank_sp_q;
        bank_mode_d  = bank_mode_q;
        bank_signs_d = bank_signs_q;
        wr_bank_d    = wr_bank_q;
        abort_d      = 1'b0;
        wr_en        = 1'b0;
        f_min1       = min1_q;
        f_min2       = min2_q;
        f_idx        = idx_q;
        f_sp         = sp_q;
        f_signs      = signs_q;
        f_mode       = mode_q;
        seg_idx      = seg_cnt_q;
        acc_lane     = '0;
        acc_mag      = '0;
        acc_eidx     = '0;
        accept       = in_valid && (first_comp || (state_q == StAcc));

        if (in_valid && first_comp) begin
            f_min1  = '1;
            f_min2  = '1;
            f_idx   = '0;
            f_sp    = 1'b0;
            f_signs = '0;
            f_mode  = ms_mode;
            seg_idx = '0;
            abort_d = (state_q == StAcc);
        end

        if (accept) begin
            // Lanes fold in ascending edge order so ties leave the lowest index as min1.
            for (int j = 0; j < int'(EXT_MSG_PARALLELISM); j++) begin
                acc_lane = var_to_ch[j*QUAN_SIZE +: QUAN_SIZE];
                acc_mag  = acc_lane[MAG_SIZE-1:0];
                acc_eidx = IDX_W'(int'(seg_idx) * int'(EXT_MSG_PARALLELISM) + j);
                if (acc_mag < f_min1) begin
                    f_min2 = f_min1;
                    f_min1 = acc_mag;
                    f_idx  = acc_eidx;
                end else if (acc_mag < f_min2) begin
                    f_min2 = acc_mag;
                end
                f_sp              = f_sp ^ acc_lane[QUAN_SIZE-1];
                f_signs[acc_eidx] = acc_lane[QUAN_SIZE-1];
            end
            min1_d  = f_min1;
            min2_d  = f_min2;
            idx_d   = f_idx;
            sp_d    = f_sp;
            signs_d = f_signs;
            mode_d  = f_mode;
            if (seg_idx == LAST_SEG) begin
                wr_en                   = 1'b1;
                state_d                 = StIdle;
                seg_cnt_d               = '0;
                bank_min1_d[wr_bank_q]  = f_min1;
                bank_min2_d[wr_bank_q]  = f_min2;
                bank_idx_d[wr_bank_q]   = f_idx;
                bank_sp_d[wr_bank_q]    = f_sp;
                bank_mode_d[wr_bank_q]  = f_mode;
                bank_signs_d[wr_bank_q] = f_signs;
                wr_bank_d               = ~wr_bank_q;
            end else begin
                state_d   = StAcc;
                seg_cnt_d = seg_idx + 1'b1;
            end
        end
    end

    // Drain sequencer: a new bank write restarts it, after the final segment of the
    // previous row has been issued on the same edge.
    always_comb begin
        drain_act_d  = drain_act_q;
        drain_bank_d = drain_bank_q;
        drain_seg_d  = drain_seg_q;
        out_valid_d  = drain_act_q;
        out_first_d  = drain_act_q && (drain_seg_q == '0);
        c2v_d        = '0;
        dr_eidx      = '0;
        dr_mag       = '0;
        dr_sign      = 1'b0;

        if (drain_act_q) begin
            for (int j = 0; j < int'(EXT_MSG_PARALLELISM); j++) begin
                dr_eidx = IDX_W'(int'(drain_seg_q) * int'(EXT_MSG_PARALLELISM) + j);
                dr_mag  = (dr_eidx == bank_idx_q[drain_bank_q]) ? bank_min2_q[drain_bank_q]
                                                                 : bank_min1_q[drain_bank_q];
                if (bank_mode_q[drain_bank_q]) begin
                    dr_mag = (dr_mag > OFF_M) ? dr_mag - OFF_M : '0;
                end
                dr_sign = bank_sp_q[drain_bank_q] ^ bank_signs_q[drain_bank_q][dr_eidx];
                c2v_d[j*QUAN_SIZE +: QUAN_SIZE] = (dr_mag == '0) ? '0 : {dr_sign, dr_mag};
            end
            if (drain_seg_q == LAST_SEG) begin
                drain_act_d = 1'b0;
            end else begin
                drain_seg_d = drain_seg_q + 1'b1;
            end
        end

        if (wr_en) begin
            drain_act_d  = 1'b1;
            drain_bank_d = wr_bank_q;
            drain_seg_d  = '0;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            seg_cnt_q    <= '0;
            min1_q       <= '0;
            min2_q       <= '0;
            idx_q        <= '0;
            sp_q         <= 1'b0;
            mode_q       <= 1'b0;
            signs_q      <= '0;
            for (int b = 0; b < 2; b++) begin
                bank_min1_q[b]  <= '0;
                bank_min2_q[b]  <= '0;
                bank_idx_q[b]   <= '0;
                bank_sp_q[b]    <= 1'b0;
                bank_mode_q[b]  <= 1'b0;
                bank_signs_q[b] <= '0;
            end
            wr_bank_q    <= 1'b0;
            drain_act_q  <= 1'b0;
            drain_bank_q <= 1'b0;
            drain_seg_q  <= '0;
            c2v_q        <= '0;
            out_valid_q  <= 1'b0;
            out_first_q  <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            seg_cnt_q    <= seg_cnt_d;
            min1_q       <= min1_d;
            min2_q       <= min2_d;
            idx_q        <= idx_d;
            sp_q         <= sp_d;
            mode_q       <= mode_d;
            signs_q      <= signs_d;
            bank_min1_q  <= bank_min1_d;
            bank_min2_q  <= bank_min2_d;
            bank_idx_q   <= bank_idx_d;
            bank_sp_q    <= bank_sp_d;
            bank_mode_q  <= bank_mode_d;
            bank_signs_q <= bank_signs_d;
            wr_bank_q    <= wr_bank_d;
            drain_act_q  <= drain_act_d;
            drain_bank_q <= drain_bank_d;
            drain_seg_q  <= drain_seg_d;
            c2v_q        <= c2v_d;
            out_valid_q  <= out_valid_d;
            out_first_q  <= out_first_d;
            abort_q      <= abort_d;
        end
    end

    assign ch_to_var = c2v_q;
    assign out_valid = out_valid_q;
    assign out_first = out_first_q;
    assign row_abort = abort_q;

endmodule
